// File: rtl/init_pkg.sv
// Shared types and the fill-pattern helper for the RAM initialiser.
package init_pkg;

  // Patterns are computed at this width, and the caller truncates to the RAM word width.
  localparam int FILL_W = 32;

  typedef enum logic [1:0] {
    FILL_IDENTITY   = 2'd0,
    FILL_CONSTANT   = 2'd1,
    FILL_DESCENDING = 2'd2,
    FILL_RSVD       = 2'd3
  } fill_mode_t;

  typedef enum logic [1:0] {
    INIT_IDLE  = 2'd0,
    INIT_WRITE = 2'd1,
    INIT_DONE  = 2'd2
  } init_state_t;

  // The reserved mode falls back to identity.
  function automatic logic [FILL_W-1:0] gen_fill(
    input fill_mode_t        mode,
    input logic [FILL_W-1:0] cur,
    input logic [FILL_W-1:0] lo,
    input logic [FILL_W-1:0] hi,
    input logic [FILL_W-1:0] fill_val
  );
    logic [FILL_W-1:0] v;
    case (mode)
      FILL_CONSTANT:   v = fill_val;
      FILL_DESCENDING: v = hi - (cur - lo);
      default:         v = cur;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mem_init_seq.sv
// Sequential RAM initialiser: writes [lo, min(hi, DEPTH-1)] one word per cycle,
// holds under stall, and pulses done once after the last accepted write.
module mem_init_seq
  import init_pkg::*;
#(
  parameter  int DEPTH  = 256,
  parameter  int DATA_W = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_val,
  input  logic [ADDR_W-1:0] lo,
  input  logic [ADDR_W-1:0] hi,
  input  logic              stall,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic              wren,
  output logic              done
);

  init_state_t       r_state, w_state_nxt;
  fill_mode_t        r_mode;
  logic [DATA_W-1:0] r_fill;
  logic [ADDR_W-1:0] r_lo, r_hi, r_cur;
  logic [DATA_W-1:0] r_wrdata;

  logic [ADDR_W-1:0] w_hi_eff, w_cur_inc;
  logic              w_empty, w_accept, w_last;
  fill_mode_t        w_mode_in;

  assign w_mode_in = fill_mode_t'(mode);
  assign w_hi_eff  = (32'(hi) > 32'(DEPTH - 1)) ? ADDR_W'(DEPTH - 1) : hi;
  assign w_empty   = lo > w_hi_eff;
  assign w_accept  = (r_state == INIT_WRITE) && !stall;
  assign w_last    = (r_cur == r_hi);
  assign w_cur_inc = r_cur + ADDR_W'(1);

  assign addr   = r_cur;
  assign wrdata = r_wrdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= INIT_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    rdy         = 1'b0;
    wren        = 1'b0;
    done        = 1'b0;
    case (r_state)
      INIT_IDLE: begin
        rdy = 1'b1;
        if (en) w_state_nxt = w_empty ? INIT_DONE : INIT_WRITE;
      end
      INIT_WRITE: begin
        wren = 1'b1;
        if (!stall && w_last) w_state_nxt = INIT_DONE;
      end
      INIT_DONE: begin
        done        = 1'b1;
        w_state_nxt = INIT_IDLE;
      end
      default: w_state_nxt = INIT_IDLE;
    endcase
  end

  // Write data is registered alongside the address so that it is stable
  // under stall and keeps its last value outside WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode   <= FILL_IDENTITY;
      r_fill   <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_cur    <= '0;
      r_wrdata <= '0;
    end else if (r_state == INIT_IDLE && en) begin
      r_mode <= w_mode_in;
      r_fill <= fill_val;
      r_lo   <= lo;
      r_hi   <= w_hi_eff;
      if (!w_empty) begin
        r_cur    <= lo;
        r_wrdata <= DATA_W'(gen_fill(w_mode_in, 32'(lo), 32'(lo),
                                     32'(w_hi_eff), 32'(fill_val)));
      end
    end else if (w_accept && !w_last) begin
      r_cur    <= w_cur_inc;
      r_wrdata <= DATA_W'(gen_fill(r_mode, 32'(w_cur_inc), 32'(r_lo),
                                   32'(r_hi), 32'(r_fill)));
    end
  end

endmodule

// File: tb/tb_mem_init_seq.sv
// Directed bench for mem_init_seq: default instance plus a 64x16 instance.
module tb_mem_init_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, stall, rdy, wren, done;
  logic [1:0] mode;
  logic [7:0] fill_val, lo, hi, addr, wrdata;

  logic        en1, stall1, rdy1, wren1, done1;
  logic [1:0]  mode1;
  logic [15:0] fill1, wrdata1;
  logic [5:0]  lo1, hi1, addr1;

  mem_init_seq dut0 (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .mode(mode), .fill_val(fill_val),
    .lo(lo), .hi(hi), .stall(stall), .addr(addr), .wrdata(wrdata),
    .wren(wren), .done(done)
  );

  mem_init_seq #(.DEPTH(64), .DATA_W(16)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .rdy(rdy1), .mode(mode1), .fill_val(fill1),
    .lo(lo1), .hi(hi1), .stall(stall1), .addr(addr1), .wrdata(wrdata1),
    .wren(wren1), .done(done1)
  );

  // RAM model behind dut0 and a done counter for dut1
  logic [7:0] mem0 [256];
  int         wcnt0 = 0;
  int         done1_cnt = 0;
  logic [7:0] last_a = '0, last_d = '0;

  always @(posedge clk) begin
    if (!rst && wren && !stall) begin
      mem0[addr] <= wrdata;
      wcnt0      <= wcnt0 + 1;
      last_a     <= addr;
      last_d     <= wrdata;
    end
    if (done1) done1_cnt <= done1_cnt + 1;
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] m, input logic [7:0] f, input logic [7:0] l,
                       input logic [7:0] h);
    mode = m; fill_val = f; lo = l; hi = h; en = 1'b1;
    step();
    en = 1'b0;
  endtask

  // Runs from the first WRITE cycle until done, optionally stalling at one
  // address and scrambling inputs every cycle.
  task automatic run(input int sat, input int slen, input bit chaos,
                     output int cyc, output int hits);
    int s;
    s = 0; cyc = 0; hits = 0;
    while (!done && cyc < 600) begin
      if (wren && addr == 8'(sat)) hits++;
      if (wren && addr == 8'(sat) && s < slen) begin stall = 1'b1; s++; end
      else stall = 1'b0;
      if (chaos) begin
        en = ~en; mode = 2'($urandom); fill_val = 8'($urandom); lo = 8'h00; hi = 8'hFF;
      end
      step();
      cyc++;
    end
    stall = 1'b0; en = 1'b0;
    chk("run_done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int cyc, hits, w0, bad, k, d0;
    rst = 1'b1; en = 1'b0; stall = 1'b0; mode = '0; fill_val = '0; lo = '0; hi = '0;
    en1 = 1'b0; stall1 = 1'b0; mode1 = '0; fill1 = '0; lo1 = '0; hi1 = '0;
    step(); step();
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wrdata", 32'(wrdata), 32'd0);
    chk("rst_rdy1", 32'(rdy1), 32'd1);
    rst = 1'b0;
    step();

    // full identity fill
    w0 = wcnt0;
    start(2'd0, 8'h00, 8'd0, 8'd255);
    chk("t1_first_wren", 32'(wren), 32'd1);
    chk("t1_first_rdy", 32'(rdy), 32'd0);
    chk("t1_first_addr", 32'(addr), 32'd0);
    run(-1, 0, 1'b0, cyc, hits);
    chk("t1_cycles", 32'(cyc), 32'd256);
    chk("t1_writes", 32'(wcnt0 - w0), 32'd256);
    step();
    chk("t1_rdy_back", 32'(rdy), 32'd1);
    chk("t1_done_low", 32'(done), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem0[i] !== 8'(i)) bad++;
    chk("t1_mem", 32'(bad), 32'd0);

    // constant fill with a 3-cycle stall at 20
    w0 = wcnt0;
    start(2'd1, 8'hA5, 8'd16, 8'd31);
    chk("t2_first_data", 32'(wrdata), 32'hA5);
    run(20, 3, 1'b0, cyc, hits);
    chk("t2_hold20", 32'(hits), 32'd4);
    chk("t2_cycles", 32'(cyc), 32'd19);
    chk("t2_writes", 32'(wcnt0 - w0), 32'd16);
    bad = 0;
    for (int i = 16; i < 32; i++) if (mem0[i] !== 8'hA5) bad++;
    chk("t2_mem", 32'(bad), 32'd0);
    chk("t2_below", 32'(mem0[15]), 32'd15);
    chk("t2_above", 32'(mem0[32]), 32'd32);
    step();

    // descending
    start(2'd2, 8'h00, 8'd10, 8'd13);
    chk("t3_first_addr", 32'(addr), 32'd10);
    chk("t3_first_data", 32'(wrdata), 32'd13);
    run(-1, 0, 1'b0, cyc, hits);
    chk("t3_cycles", 32'(cyc), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_mem", 32'(mem0[10 + i]), 32'(13 - i));
    step();

    // empty range
    w0 = wcnt0;
    start(2'd0, 8'h00, 8'd50, 8'd40);
    chk("t4_no_wren", 32'(wren), 32'd0);
    chk("t4_done", 32'(done), 32'd1);
    step();
    chk("t4_rdy", 32'(rdy), 32'd1);
    chk("t4_writes", 32'(wcnt0 - w0), 32'd0);

    // single word
    w0 = wcnt0;
    start(2'd0, 8'h00, 8'd7, 8'd7);
    run(-1, 0, 1'b0, cyc, hits);
    chk("t5_cycles", 32'(cyc), 32'd1);
    chk("t5_writes", 32'(wcnt0 - w0), 32'd1);
    chk("t5_addr", 32'(last_a), 32'd7);
    chk("t5_data", 32'(last_d), 32'd7);
    step();

    // inputs scrambled mid-fill are ignored
    start(2'd1, 8'h3C, 8'd100, 8'd107);
    run(-1, 0, 1'b1, cyc, hits);
    chk("t6_cycles", 32'(cyc), 32'd8);
    bad = 0;
    for (int i = 100; i < 108; i++) if (mem0[i] !== 8'h3C) bad++;
    chk("t6_mem", 32'(bad), 32'd0);
    step();

    // reserved mode behaves as identity
    start(2'd3, 8'hEE, 8'd100, 8'd103);
    run(-1, 0, 1'b0, cyc, hits);
    for (int i = 0; i < 4; i++) chk("t7_mem", 32'(mem0[100 + i]), 32'(100 + i));
    step();

    // 64x16 instance: reset mid-fill then restart
    mode1 = 2'd0; lo1 = 6'd0; hi1 = 6'd63; en1 = 1'b1;
    step();
    en1 = 1'b0;
    k = 0;
    while (addr1 != 6'd30 && k < 100) begin step(); k++; end
    chk("d1_reach30", 32'(addr1), 32'd30);
    chk("d1_data30", 32'(wrdata1), 32'd30);
    d0 = done1_cnt;
    rst = 1'b1;
    step();
    chk("d1_rst_wren", 32'(wren1), 32'd0);
    chk("d1_rst_rdy", 32'(rdy1), 32'd1);
    chk("d1_rst_addr", 32'(addr1), 32'd0);
    rst = 1'b0;
    step(); step();
    chk("d1_no_done", 32'(done1_cnt - d0), 32'd0);
    lo1 = 6'd5; hi1 = 6'd6; en1 = 1'b1;
    step();
    en1 = 1'b0;
    chk("d1_restart_addr", 32'(addr1), 32'd5);
    chk("d1_restart_data", 32'(wrdata1), 32'd5);
    chk("d1_restart_wren", 32'(wren1), 32'd1);
    step();
    chk("d1_second_addr", 32'(addr1), 32'd6);
    step();
    chk("d1_done", 32'(done1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
